array_packed_3d_serializer: RTL and testbench
=============================================

# array_packed_3d_serializer

Downstream consumer of a packed 3D array stage. Captures one whole `[N1-1:0][N2-1:0][N3-1:0][DW-1:0]` packed array through a valid/ready handshake and streams it out one element per beat. Each beat carries its `(i,j,k)` index. Order is `i` outermost and `k` innermost, matching the fill order of the producer. Its purpose is to turn a parallel array into a sequential element stream for checkers and waveform comparison.

## Interface
- `N1`, 4, size of dimension 1 (outermost, `i`)
- `N2`, 3, size of dimension 2 (`j`)
- `N3`, 2, size of dimension 3 (`k`)
- `DW`, 8, element width in bits
- All four parameters are ≥1.
- `IW1`/`IW2`/`IW3` (localparam) = `max(1,$clog2(Nx))`.

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `in_valid`  in  1  input array offered
- `in_ready`  out  1  block can accept an array
- `in_data`  in  `N1*N2*N3*DW`  packed array; element `[i][j][k]` at bit offset `((i*N2+j)*N3+k)*DW`
- `out_valid`  out  1  element beat valid
- `out_ready`  in  1  sink accepts beat
- `out_data`  out  `DW`  element value
- `out_i` / `out_j` / `out_k`  out  `IW1`/`IW2`/`IW3`  element indices
- `out_last`  out  1  beat is element `[N1-1][N2-1][N3-1]`
- `busy`  out  1  high while in SEND

## Operation
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- FSM has two states: IDLE and SEND.
- **IDLE**
  - `in_ready=1`, `out_valid=0`.
  - On `in_valid && in_ready` at a rising edge: register `in_data` into a shadow register, set `i=j=k=0`, go to SEND.
- **SEND**
  - `in_ready=0`, `out_valid=1`, `busy=1`.
  - `out_data` = shadow element `[i][j][k]`; indices drive `out_i/j/k`.
  - On `out_valid && out_ready`:
    - `k` increments.
    - At `k==N3-1`, `k` wraps to 0 and `j` increments.
    - At `j==N2-1`, `j` wraps to 0 and `i` increments.
  - Accepting the beat with `out_last=1` returns the FSM to IDLE and clears the indices to 0.
- `out_last` = `(i==N1-1)&&(j==N2-1)&&(k==N3-1)&&out_valid`.
- Shadow register is written only on the input handshake. `in_data` changes during SEND have no effect.
- Dimensions of size 1: that index stays at 0 and every step carries straight into the next-outer index.
- Stream length per array = `N1*N2*N3` beats; default 24.

## Timing
- Reset (asynchronous, immediate): state=IDLE, indices=0, shadow=0.
- Output values during reset: `in_ready=1`, `out_valid=0`, `out_data=0`, `out_i/j/k=0`, `out_last=0`, `busy=0`.
- Reset mid-stream aborts the array. No further beats are emitted until a new input handshake.
- Latency: input handshake at edge N gives `out_valid=1` with element `[0][0][0]` in the cycle after edge N.
- Backpressure: while `out_valid && !out_ready`, `out_data`, `out_i/j/k` and `out_last` hold stable.
- `out_valid` never drops before the beat is accepted.
- One IDLE cycle between arrays: `in_ready` rises in the cycle after the last beat is accepted.
- Minimum period per array with `out_ready=1`: `N1*N2*N3+1` cycles (25 at defaults).
- No combinational path from `out_ready` or `in_valid` to any output. All outputs decode directly from registers.

## Test plan
- **Default fill, full throughput.** Load each element `[i][j][k]` with `i+j+k`; hold `out_ready=1`.
  - Expect 24 consecutive beats with `out_data` = 0,1,1,2,2,3, 1,2,2,3,3,4, 2,3,3,4,4,5, 3,4,4,5,5,6.
  - Indices follow k-fastest order; `out_last` is high only on beat 24 (3,2,1).
- **Backpressure.** Same input; drive `out_ready` with the pattern 1,0,0,1 repeating.
  - Every beat is held stable through its stall cycles.
  - Same 24-value sequence; no beat lost or duplicated.
- **Input isolation and back-to-back arrays.** Change `in_data` to all-`0xFF` during SEND and keep `in_valid=1`.
  - The current stream is unaffected.
  - Exactly one idle cycle after `out_last`, then the second array streams all `0xFF`.
- **Asynchronous reset mid-stream.** Assert `rst_n=0` between edges after beat 10.
  - `out_valid`, `busy` and `out_data` drop immediately and `in_ready=1`.
  - After release, a new array streams starting at `[0][0][0]`.
- **Degenerate dimensions.** Parameters `N1=2, N2=1, N3=1, DW=4`, input `0x21`.
  - Beats `1` at (0,0,0) then `2` at (1,0,0) with `out_last`.
  - `out_j` and `out_k` stay 0.

Source files
------------

// File: rtl/array_packed_3d_serializer_if.sv
// Stream bundle for array_packed_3d_serializer: array-wide input side and
// element-wide output side. The master modport is the producer/sink
// environment; the slave modport is the serializer itself.
interface array_packed_3d_serializer_if #(
  parameter int unsigned N1 = 4,
  parameter int unsigned N2 = 3,
  parameter int unsigned N3 = 2,
  parameter int unsigned DW = 8
) ();
  localparam int unsigned IW1 = (N1 > 1) ? $clog2(N1) : 1;
  localparam int unsigned IW2 = (N2 > 1) ? $clog2(N2) : 1;
  localparam int unsigned IW3 = (N3 > 1) ? $clog2(N3) : 1;
  localparam int unsigned Width = N1 * N2 * N3 * DW;

  // Array input side
  logic             in_valid;
  logic             in_ready;
  logic [Width-1:0] in_data;

  // Element output side
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    out_data;
  logic [IW1-1:0]   out_i;
  logic [IW2-1:0]   out_j;
  logic [IW3-1:0]   out_k;
  logic             out_last;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_i,
    input  out_j,
    input  out_k,
    input  out_last
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_i,
    output out_j,
    output out_k,
    output out_last
  );
endinterface

// File: rtl/array_packed_3d_serializer.sv
// Captures a packed [N1][N2][N3][DW] array on a valid/ready handshake and
// replays it one element per beat, i outermost and k innermost, tagging each
// beat with its (i,j,k) index. All outputs decode from registers only.
module array_packed_3d_serializer #(
  parameter int unsigned N1 = 4,
  parameter int unsigned N2 = 3,
  parameter int unsigned N3 = 2,
  parameter int unsigned DW = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  array_packed_3d_serializer_if.slave   bus,
  output logic                          busy
);
  localparam int unsigned IW1   = (N1 > 1) ? $clog2(N1) : 1;
  localparam int unsigned IW2   = (N2 > 1) ? $clog2(N2) : 1;
  localparam int unsigned IW3   = (N3 > 1) ? $clog2(N3) : 1;
  localparam int unsigned Width = N1 * N2 * N3 * DW;

  localparam logic [IW1-1:0] IMax = IW1'(N1 - 1);
  localparam logic [IW2-1:0] JMax = IW2'(N2 - 1);
  localparam logic [IW3-1:0] KMax = IW3'(N3 - 1);

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StSend = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [Width-1:0] shadow_q, shadow_d;
  logic [IW1-1:0]   i_q, i_d;
  logic [IW2-1:0]   j_q, j_d;
  logic [IW3-1:0]   k_q, k_d;

  logic             sending;
  logic             at_last;
  logic [31:0]      flat_idx;
  logic [Width-1:0] shadow_shifted;

  assign sending = (state_q == StSend);
  assign at_last = (i_q == IMax) && (j_q == JMax) && (k_q == KMax);

  // Element select: flat position of [i][j][k] in the captured array.
  always_comb begin
    flat_idx       = (32'(i_q) * N2 + 32'(j_q)) * N3 + 32'(k_q);
    shadow_shifted = shadow_q >> (flat_idx * DW);
  end

  // State, shadow array and index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      shadow_q <= '0;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
    end
  end

  // Next state: capture on input handshake, k-fastest index walk on each
  // accepted beat, with carries rippling outward through wrapped indices.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;

    unique case (state_q)
      StIdle: begin
        // in_ready is constantly high here, so in_valid alone completes it.
        if (bus.in_valid) begin
          shadow_d = bus.in_data;
          i_d      = '0;
          j_d      = '0;
          k_d      = '0;
          state_d  = StSend;
        end
      end

      StSend: begin
        if (bus.out_ready) begin
          if (at_last) begin
            i_d     = '0;
            j_d     = '0;
            k_d     = '0;
            state_d = StIdle;
          end else if (k_q != KMax) begin
            k_d = k_q + 1'b1;
          end else begin
            k_d = '0;
            if (j_q != JMax) begin
              j_d = j_q + 1'b1;
            end else begin
              j_d = '0;
              i_d = i_q + 1'b1;
            end
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // Outputs: pure decode of registered state; data forced to zero when idle.
  always_comb begin
    bus.in_ready  = !sending;
    bus.out_valid = sending;
    bus.out_data  = sending ? shadow_shifted[DW-1:0] : '0;
    bus.out_i     = i_q;
    bus.out_j     = j_q;
    bus.out_k     = k_q;
    bus.out_last  = sending && at_last;
    busy          = sending;
  end

endmodule

// File: tb/tb_array_packed_3d_serializer.sv
// Bench for array_packed_3d_serializer: default-size instance exercised with
// directed and random arrays under several out_ready patterns, plus a
// degenerate 2x1x1 instance.
module tb_array_packed_3d_serializer;
  localparam int unsigned N1 = 4;
  localparam int unsigned N2 = 3;
  localparam int unsigned N3 = 2;
  localparam int unsigned DW = 8;
  localparam int unsigned NE = N1 * N2 * N3;
  localparam int unsigned W  = NE * DW;

  logic clk;
  logic rst_n;
  logic busy;
  logic busy2;

  int tests = 0;
  int fails = 0;

  array_packed_3d_serializer_if #(.N1(N1), .N2(N2), .N3(N3), .DW(DW)) bus ();
  array_packed_3d_serializer_if #(.N1(2), .N2(1), .N3(1), .DW(4)) bus2 ();

  array_packed_3d_serializer #(.N1(N1), .N2(N2), .N3(N3), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  array_packed_3d_serializer #(.N1(2), .N2(1), .N3(1), .DW(4)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2),
    .busy  (busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before 200000ns");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_arr();
    logic [W-1:0] r;
    for (int e = 0; e < NE; e++) r[e*DW +: DW] = DW'($urandom);
    return r;
  endfunction

  function automatic logic [W-1:0] fill_sum();
    logic [W-1:0] r;
    for (int i = 0; i < N1; i++)
      for (int j = 0; j < N2; j++)
        for (int k = 0; k < N3; k++)
          r[((i*N2 + j)*N3 + k)*DW +: DW] = DW'(i + j + k);
    return r;
  endfunction

  // Offers one array at the next edge and consumes beats against an expected
  // list built from the array contents. mode: 0 ready always, 1 pattern
  // 1,0,0,1, 2 random. chain keeps in_valid high with next_data during SEND.
  // Returns early after abort_after accepted beats.
  task automatic send_array(input logic [W-1:0] data, input int mode, input bit chain,
                            input logic [W-1:0] next_data, input int abort_after);
    logic [DW-1:0] ed [NE];
    int ei [NE];
    int ej [NE];
    int ek [NE];
    int n;
    int beat;
    int cyc;
    bit r;
    n = 0;
    for (int i = 0; i < N1; i++)
      for (int j = 0; j < N2; j++)
        for (int k = 0; k < N3; k++) begin
          ed[n] = data[((i*N2 + j)*N3 + k)*DW +: DW];
          ei[n] = i;
          ej[n] = j;
          ek[n] = k;
          n++;
        end

    chk("idle_in_ready", 64'(bus.in_ready), 64'(1));
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    @(posedge clk); #1;
    if (chain) begin
      bus.in_data = next_data;
    end else begin
      bus.in_valid = 1'b0;
      bus.in_data  = rand_arr();
    end

    beat = 0;
    cyc  = 0;
    while (beat < abort_after && cyc < 400) begin
      chk("out_valid", 64'(bus.out_valid), 64'(1));
      chk("busy", 64'(busy), 64'(1));
      chk("in_ready_send", 64'(bus.in_ready), 64'(0));
      chk("out_data", 64'(bus.out_data), 64'(ed[beat]));
      chk("out_i", 64'(bus.out_i), 64'(ei[beat]));
      chk("out_j", 64'(bus.out_j), 64'(ej[beat]));
      chk("out_k", 64'(bus.out_k), 64'(ek[beat]));
      chk("out_last", 64'(bus.out_last), 64'(beat == NE - 1));
      case (mode)
        0:       r = 1'b1;
        1:       r = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: r = 1'($urandom_range(0, 1));
      endcase
      bus.out_ready = r;
      @(posedge clk); #1;
      if (r) beat++;
      cyc++;
    end
    chk("beat_count", 64'(beat), 64'(abort_after));
    if (abort_after == NE) begin
      chk("gap_out_valid", 64'(bus.out_valid), 64'(0));
      chk("gap_in_ready", 64'(bus.in_ready), 64'(1));
      chk("gap_busy", 64'(busy), 64'(0));
      chk("gap_out_last", 64'(bus.out_last), 64'(0));
    end
    bus.out_ready = 1'($urandom_range(0, 1));
  endtask

  initial begin
    logic [W-1:0] ff_arr;
    ff_arr = '1;

    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.out_ready  = 1'b0;
    bus2.in_valid  = 1'b0;
    bus2.in_data   = '0;
    bus2.out_ready = 1'b0;

    // Reset values, both before any edge and with edges under reset.
    #3;
    chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_out_data", 64'(bus.out_data), 64'(0));
    chk("rst_out_last", 64'(bus.out_last), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    bus.in_valid  = 1'b1;
    bus.in_data   = rand_arr();
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_hold_idx", 64'({bus.out_i, bus.out_j, bus.out_k}), 64'(0));
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_idle", 64'(bus.out_valid), 64'(0));

    // Default fill i+j+k at full throughput, then with 1,0,0,1 backpressure.
    send_array(fill_sum(), 0, 1'b0, '0, NE);
    send_array(fill_sum(), 1, 1'b0, '0, NE);

    // Input isolation and back-to-back: in_data goes all-ones during SEND.
    send_array(fill_sum(), 0, 1'b1, ff_arr, NE);
    send_array(ff_arr, 0, 1'b0, '0, NE);

    // Random arrays with random backpressure.
    for (int t = 0; t < 3; t++) send_array(rand_arr(), 2, 1'b0, '0, NE);

    // Asynchronous reset after beat 10.
    send_array(rand_arr(), 0, 1'b0, '0, 10);
    rst_n = 1'b0;
    #2;
    chk("async_out_valid", 64'(bus.out_valid), 64'(0));
    chk("async_busy", 64'(busy), 64'(0));
    chk("async_out_data", 64'(bus.out_data), 64'(0));
    chk("async_in_ready", 64'(bus.in_ready), 64'(1));
    chk("async_idx", 64'({bus.out_i, bus.out_j, bus.out_k}), 64'(0));
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("post_abort_idle", 64'(bus.out_valid), 64'(0));
    end
    send_array(rand_arr(), 1, 1'b0, '0, NE);

    // Degenerate 2x1x1 of 4-bit elements, input 0x21.
    bus2.in_valid  = 1'b1;
    bus2.in_data   = 8'h21;
    bus2.out_ready = 1'b1;
    @(posedge clk); #1;
    bus2.in_valid = 1'b0;
    chk("deg0_valid", 64'(bus2.out_valid), 64'(1));
    chk("deg0_data", 64'(bus2.out_data), 64'(1));
    chk("deg0_i", 64'(bus2.out_i), 64'(0));
    chk("deg0_jk", 64'({bus2.out_j, bus2.out_k}), 64'(0));
    chk("deg0_last", 64'(bus2.out_last), 64'(0));
    @(posedge clk); #1;
    chk("deg1_valid", 64'(bus2.out_valid), 64'(1));
    chk("deg1_data", 64'(bus2.out_data), 64'(2));
    chk("deg1_i", 64'(bus2.out_i), 64'(1));
    chk("deg1_jk", 64'({bus2.out_j, bus2.out_k}), 64'(0));
    chk("deg1_last", 64'(bus2.out_last), 64'(1));
    @(posedge clk); #1;
    chk("deg_gap_valid", 64'(bus2.out_valid), 64'(0));
    chk("deg_gap_in_ready", 64'(bus2.in_ready), 64'(1));
    chk("deg_gap_busy", 64'(busy2), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
